// File: rtl/nios2_led_fader.sv
// PWM fader between the Nios II LED PIO and the board LEDs: each of the 10 LEDs
// has a 16-level brightness that ramps toward the commanded on/off state.
module nios2_led_fader #(
  parameter int PRESCALE  = 50,
  parameter int FADE_STEP = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] led_in,
  input  logic       fade_en,
  output logic [9:0] led_out,
  output logic       busy
);

  localparam int PRE_W  = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
  localparam int STEP_W = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP - 1);

  logic [9:0]        led_in_r;
  logic [PRE_W-1:0]  pre_cnt;
  logic [3:0]        pwm_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [3:0]        level  [10];
  logic [3:0]        target [10];
  logic              tick;
  logic              period_end;
  logic              step;
  logic              any_diff;

  always_comb begin
    tick       = (pre_cnt == PRE_LAST);
    period_end = tick && (pwm_cnt == 4'd14);
    step       = period_end && (step_cnt == STEP_LAST);
    any_diff   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      target[i] = led_in_r[i] ? 4'd15 : 4'd0;
      if (level[i] != target[i]) any_diff = 1'b1;
    end
  end

  // Counters free-run; input changes never resynchronise the PWM phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_in_r <= '0;
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
      led_out  <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < 10; i++) level[i] <= '0;
    end else begin
      led_in_r <= led_in;
      pre_cnt  <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) pwm_cnt <= (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;
      if (period_end) step_cnt <= step ? '0 : step_cnt + 1'b1;
      for (int i = 0; i < 10; i++) begin
        if (!fade_en) begin
          level[i] <= target[i];
        end else if (step) begin
          if (led_in_r[i] && level[i] != 4'd15)      level[i] <= level[i] + 4'd1;
          else if (!led_in_r[i] && level[i] != 4'd0) level[i] <= level[i] - 4'd1;
        end
        // pwm_cnt tops out at 14, so level 15 is always on and level 0 always off.
        led_out[i] <= (level[i] > pwm_cnt);
      end
      busy <= fade_en && any_diff;
    end
  end

endmodule

// File: tb/tb_nios2_led_fader.sv
// Bench for nios2_led_fader: two parameterisations driven with shared stimulus,
// each compared every cycle against an arithmetic reference model.
module tb_nios2_led_fader;

  localparam int NI = 2;
  localparam int MP [NI] = '{2, 3};
  localparam int MF [NI] = '{1, 2};

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] led_in;
  logic       fade_en;
  logic [9:0] out0, out1;
  logic       busy0, busy1;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  // Reference state: mt = clock edges since reset; counter phases derive from it.
  int         mt    [NI];
  logic [9:0] mlir  [NI];
  logic [3:0] mlvl  [NI][10];
  logic [9:0] mout  [NI];
  logic       mbusy [NI];

  always #5 clk = ~clk;

  nios2_led_fader #(.PRESCALE(2), .FADE_STEP(1)) u0 (
    .clk(clk), .reset(reset), .led_in(led_in), .fade_en(fade_en),
    .led_out(out0), .busy(busy0)
  );

  nios2_led_fader #(.PRESCALE(3), .FADE_STEP(2)) u1 (
    .clk(clk), .reset(reset), .led_in(led_in), .fade_en(fade_en),
    .led_out(out1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int         pwm;
    bit         stp;
    bit         diff;
    logic [3:0] tgt;
    logic [9:0] nout;
    for (int m = 0; m < NI; m++) begin
      if (reset) begin
        mt[m]    = 0;
        mlir[m]  = '0;
        mout[m]  = '0;
        mbusy[m] = 1'b0;
        for (int i = 0; i < 10; i++) mlvl[m][i] = '0;
      end else begin
        pwm  = (mt[m] / MP[m]) % 15;
        stp  = ((mt[m] + 1) % (15 * MP[m] * MF[m])) == 0;
        diff = 1'b0;
        nout = '0;
        for (int i = 0; i < 10; i++) begin
          tgt     = mlir[m][i] ? 4'd15 : 4'd0;
          nout[i] = (int'(mlvl[m][i]) > pwm);
          if (mlvl[m][i] != tgt) diff = 1'b1;
        end
        mout[m]  = nout;
        mbusy[m] = fade_en && diff;
        for (int i = 0; i < 10; i++) begin
          tgt = mlir[m][i] ? 4'd15 : 4'd0;
          if (!fade_en) mlvl[m][i] = tgt;
          else if (stp) begin
            if (mlir[m][i] && mlvl[m][i] < 4'd15)      mlvl[m][i] = mlvl[m][i] + 4'd1;
            else if (!mlir[m][i] && mlvl[m][i] > 4'd0) mlvl[m][i] = mlvl[m][i] - 4'd1;
          end
        end
        mlir[m] = led_in;
        mt[m]++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      started = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("led_out_u0", 32'(out0), 32'(mout[0]));
      chk("busy_u0",    32'(busy0), 32'(mbusy[0]));
      chk("led_out_u1", 32'(out1), 32'(mout[1]));
      chk("busy_u1",    32'(busy1), 32'(mbusy[1]));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Bounded wait on the model's level for LED 0 of u0, then confirm the DUT agrees.
  task automatic wait_lvl0(input int v, input int budget, input string tag);
    int n = 0;
    while (int'(mlvl[0][0]) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(u0.level[0]), 32'(v));
  endtask

  initial begin
    reset   = 1'b1;
    led_in  = 10'h3FF;
    fade_en = 1'b1;
    run(3);
    reset = 1'b0;
    run(2);

    // snap mode
    pulse_reset();
    fade_en = 1'b0;
    led_in  = 10'h000;
    run(10);
    led_in = 10'h2A5;
    run(100);

    // fade up from 0 to 15 on LED 0
    pulse_reset();
    fade_en = 1'b1;
    led_in  = 10'h001;
    run(500);

    // reversal at level 7
    pulse_reset();
    led_in = 10'h001;
    wait_lvl0(7, 400, "reach_lvl7");
    led_in = 10'h000;
    run(300);

    // mode switch at level 5
    pulse_reset();
    led_in = 10'h001;
    wait_lvl0(5, 300, "reach_lvl5");
    fade_en = 1'b0;
    run(5);
    fade_en = 1'b1;
    run(40);

    // reset mid-fade with all LEDs at level 9
    pulse_reset();
    led_in = 10'h3FF;
    wait_lvl0(9, 400, "reach_lvl9");
    pulse_reset();
    run(100);

    // randomized segments, including fast toggling across step edges
    for (int k = 0; k < 40; k++) begin
      led_in  = 10'($urandom);
      fade_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) pulse_reset();
      if ($urandom_range(0, 4) == 0) begin
        for (int c = 0; c < 40; c++) begin
          led_in = 10'($urandom);
          run(1);
        end
      end else begin
        run($urandom_range(1, 250));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
